hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised data-hazard unit for the in-order pipelined CPU; sits beside the ID stage.
- Tracks destination tags of in-flight instructions in an internal shadow pipeline of DEPTH slots (slot 0 = EX, slot DEPTH-1 = WB).
- Drives per-operand forwarding (rs/rt) from any later stage and raises a stall only when the newest producer's data is not yet available.
- Replaces the stall-only scheme: a load-use hazard costs the minimum bubbles set by its ready stage, and branch flushes are folded in.

Parameters:
- DEPTH, 3, number of tracked stages after ID (EX..WB), ≥2
- ADDR_W, 5, register address width
- DATA_W, 32, datapath width
- ALU_READY, 1, slot index from which a non-load result is valid in stage_data
- LOAD_READY, 2, slot index from which a load result is valid; LOAD_READY ≥ ALU_READY, < DEPTH

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  ADDR_W each  source register addresses
- id_use_rs, id_use_rt  in  1 each  operand actually read
- id_dest  in  ADDR_W  destination register
- id_we  in  1  instruction writes the register file
- id_is_load  in  1  result comes from memory
- ex_flush  in  1  branch/jump resolved taken in EX; ID instruction is wrong-path
- stage_data  in  DEPTH*DATA_W  value held by slot i at bits [i*DATA_W +: DATA_W]
- rf_rs_data, rf_rt_data  in  DATA_W each  register-file read data
- stall  out  1  freeze PC and IF/ID; insert a bubble into EX
- rs_sel, rt_sel  out  $clog2(DEPTH+1) each  0 = register file; i+1 = slot i
- rs_data, rt_data  out  DATA_W each  selected operand value

Behaviour:
Slot state:
- Each slot holds {v, we, dest, ready_idx}.
- ready_idx = LOAD_READY if id_is_load, else ALU_READY.

Shift (every cycle, no enable):
- Slot i+1 takes slot i.
- Slot 0 takes the ID instruction when id_valid & !stall & !ex_flush; otherwise slot 0 takes a bubble (v=0).
- The slot DEPTH-1 entry is discarded.

Match (per operand, combinational):
- A slot matches when v & we & dest==addr & addr!=0 & the operand is used.
- The youngest match (lowest i) wins.
- If no match: sel=0, data=rf.
- If a match is found and i ≥ ready_idx: sel=i+1, data=stage_data slot i.
- If a match is found and i < ready_idx: the operand is not ready.

Stall:
- stall = id_valid & !ex_flush & (rs not ready | rt not ready).
- ex_flush forces stall=0 the same cycle so the PC can load the target.
- During stall: the ID instruction is held, slot 0 receives a bubble, and sel/data still reflect the current match.

Latency and boundary rules:
- stall, sel and data are combinational from slot registers and ID inputs; slot registers update at posedge.
- Load immediately followed by a dependent instruction (defaults): 2 bubbles, then forward from slot 2.
- ALU result followed by a dependent instruction: 1 bubble, then forward from slot 1.
- Register 0 never matches; its data is the register-file value (0).
- The WB slot (DEPTH-1) always forwards when it matches. This covers the write-and-read-same-cycle register-file case.
- id_valid=0: stall=0, sel=0.

Reset:
- All slots v=0.
- Hence stall=0 and sel=0 after reset; data = rf inputs.
- rst mid-stall clears all hazards on the next cycle.

Optional Feature:
- Macro HZ_PERF_EN.
- When defined, adds outputs:
  - stall_cnt (32), counts cycles with stall=1
  - fwd_cnt (32), counts cycles where rs_sel or rt_sel is non-zero while stall=0
- Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan (defaults):
- Independent instructions: add r1,r2,r3 then sub r4,r5,r6 -> stall=0, rs_sel=rt_sel=0, rs_data=rf_rs_data.
- ALU dependency: add r1 (result 0x0000_0010) then or r7,r1,r0 -> stall=1 for 1 cycle, then rs_sel=2, rs_data=0x0000_0010.
- Load-use: lw r8 (mem returns 0xDEAD_BEEF) then add r9,r8,r8 -> stall=1 for 2 cycles, then rs_sel=rt_sel=3, data=0xDEAD_BEEF.
- Youngest wins: add r3 (=5) then add r3 (=9) then use r3 -> forwards 9, never 5.
- Flush under stall: lw r2 then dependent instruction with ex_flush=1 in the same cycle -> stall=0, slot 0 gets a bubble, next cycle no match on r2 from the flushed instruction.
- r0 and reset: instruction writes r0, next instruction reads r0 -> stall=0, sel=0; assert rst during a load-use stall -> stall=0 on the following cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard unit: shadow tag pipeline, forwarding select, load-use stall
// Optional HZ_PERF_EN adds saturating stall_cnt / fwd_cnt outputs.
module hazard_scoreboard #(
  parameter int DEPTH      = 3,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [ADDR_W-1:0]           id_rs,
  input  logic [ADDR_W-1:0]           id_rt,
  input  logic                        id_use_rs,
  input  logic                        id_use_rt,
  input  logic [ADDR_W-1:0]           id_dest,
  input  logic                        id_we,
  input  logic                        id_is_load,
  input  logic                        ex_flush,
  input  logic [DEPTH*DATA_W-1:0]     stage_data,
  input  logic [DATA_W-1:0]           rf_rs_data,
  input  logic [DATA_W-1:0]           rf_rt_data,
  output logic                        stall,
  output logic [$clog2(DEPTH+1)-1:0]  rs_sel,
  output logic [$clog2(DEPTH+1)-1:0]  rt_sel,
  output logic [DATA_W-1:0]           rs_data,
  output logic [DATA_W-1:0]           rt_data
`ifdef HZ_PERF_EN
  ,
  output logic [31:0]                 stall_cnt,
  output logic [31:0]                 fwd_cnt
`endif
);

  localparam int SEL_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  slotV;
  logic [DEPTH-1:0]  slotWe;
  logic [ADDR_W-1:0] slotDest [DEPTH];
  logic [IDX_W-1:0]  slotRdy  [DEPTH];

  logic             issue;
  logic [IDX_W-1:0] readyIn;
  logic             rsLive, rtLive;
  logic             rsHit, rtHit;
  logic [IDX_W-1:0] rsIdx, rtIdx, rsRdy, rtRdy;
  logic             rsWait, rtWait, rsFwd, rtFwd;

  assign issue   = id_valid & ~stall & ~ex_flush;
  assign readyIn = id_is_load ? IDX_W'(LOAD_READY) : IDX_W'(ALU_READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      slotV <= '0;
    end else begin
      slotV <= {slotV[DEPTH-2:0], issue};
    end
  end

  // Payload needs no reset: it is only consulted behind slotV.
  always_ff @(posedge clk) begin
    slotWe      <= {slotWe[DEPTH-2:0], id_we};
    slotDest[0] <= id_dest;
    slotRdy[0]  <= readyIn;
    for (int i = 1; i < DEPTH; i++) begin
      slotDest[i] <= slotDest[i-1];
      slotRdy[i]  <= slotRdy[i-1];
    end
  end

  assign rsLive = id_valid & id_use_rs & (id_rs != '0);
  assign rtLive = id_valid & id_use_rt & (id_rt != '0);

  // Scan oldest to youngest so the youngest producer overwrites older hits.
  always_comb begin
    rsHit = 1'b0;
    rtHit = 1'b0;
    rsIdx = '0;
    rtIdx = '0;
    rsRdy = '0;
    rtRdy = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (rsLive && slotV[i] && slotWe[i] && slotDest[i] == id_rs) begin
        rsHit = 1'b1;
        rsIdx = IDX_W'(i);
        rsRdy = slotRdy[i];
      end
      if (rtLive && slotV[i] && slotWe[i] && slotDest[i] == id_rt) begin
        rtHit = 1'b1;
        rtIdx = IDX_W'(i);
        rtRdy = slotRdy[i];
      end
    end
  end

  assign rsWait = rsHit & (rsIdx < rsRdy);
  assign rtWait = rtHit & (rtIdx < rtRdy);
  assign rsFwd  = rsHit & ~rsWait;
  assign rtFwd  = rtHit & ~rtWait;

  assign stall   = id_valid & ~ex_flush & (rsWait | rtWait);
  assign rs_sel  = rsFwd ? SEL_W'(rsIdx) + SEL_W'(1) : '0;
  assign rt_sel  = rtFwd ? SEL_W'(rtIdx) + SEL_W'(1) : '0;
  assign rs_data = rsFwd ? stage_data[rsIdx*DATA_W +: DATA_W] : rf_rs_data;
  assign rt_data = rtFwd ? stage_data[rtIdx*DATA_W +: DATA_W] : rf_rt_data;

`ifdef HZ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (!stall && (rs_sel != '0 || rt_sel != '0) && fwd_cnt != 32'hFFFF_FFFF)
        fwd_cnt <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard with an in-flight list reference model
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct {
    bit          v;
    bit [AW-1:0] rs, rt;
    bit          urs, urt;
    bit [AW-1:0] dest;
    bit          we, ld;
    bit [DW-1:0] val;
  } instr_t;

  typedef struct {
    bit          v, we, ld;
    bit [AW-1:0] dest;
    bit [DW-1:0] val;
  } entry_t;

  typedef struct {
    bit          stall;
    bit [1:0]    rsSel, rtSel;
    bit [DW-1:0] rsData, rtData;
  } exp_t;

  logic              clk = 0;
  logic              rst = 1;
  logic              id_valid = 0, id_use_rs = 0, id_use_rt = 0, id_we = 0, id_is_load = 0, ex_flush = 0;
  logic [AW-1:0]     id_rs = 0, id_rt = 0, id_dest = 0;
  logic [DEPTH*DW-1:0] stage_data = 0;
  logic [DW-1:0]     rf_rs_data = 0, rf_rt_data = 0;
  logic              stall;
  logic [1:0]        rs_sel, rt_sel;
  logic [DW-1:0]     rs_data, rt_data;
`ifdef HZ_PERF_EN
  logic [31:0]       stall_cnt, fwd_cnt;
  int unsigned       expStallCnt = 0, expFwdCnt = 0;
`endif

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_we(id_we),
    .id_is_load(id_is_load), .ex_flush(ex_flush), .stage_data(stage_data),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .stall(stall),
    .rs_sel(rs_sel), .rt_sel(rt_sel), .rs_data(rs_data), .rt_data(rt_data)
`ifdef HZ_PERF_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  entry_t pipe[$];
  exp_t   expQ[$];
  int     checks = 0;
  int     errors = 0;
  bit     lastStall;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  // Youngest in-flight writer of the register decides; it forwards only once old enough.
  function automatic void lookup(input bit live, input bit [AW-1:0] a, input bit [DW-1:0] rf,
                                 output bit notRdy, output bit [1:0] sel, output bit [DW-1:0] data);
    notRdy = 0;
    sel    = 0;
    data   = rf;
    if (!live || a == 0) return;
    for (int age = 0; age < DEPTH; age++) begin
      if (pipe[age].v && pipe[age].we && pipe[age].dest == a) begin
        if (age >= (pipe[age].ld ? 2 : 1)) begin
          sel  = 2'(age + 1);
          data = pipe[age].val;
        end else begin
          notRdy = 1;
        end
        return;
      end
    end
  endfunction

  function automatic instr_t mk(bit v, int rs, int rt, bit urs, bit urt, int dest, bit we, bit ld, bit [DW-1:0] val);
    instr_t t;
    t.v = v; t.rs = AW'(rs); t.rt = AW'(rt); t.urs = urs; t.urt = urt;
    t.dest = AW'(dest); t.we = we; t.ld = ld; t.val = val;
    return t;
  endfunction

  task automatic cycle(input instr_t in, input bit flush, input bit r);
    exp_t   e;
    entry_t n;
    bit     nrRs, nrRt;
    @(posedge clk);
    #1;
    rst = r; ex_flush = flush;
    id_valid = in.v; id_rs = in.rs; id_rt = in.rt; id_use_rs = in.urs; id_use_rt = in.urt;
    id_dest = in.dest; id_we = in.we; id_is_load = in.ld;
    rf_rs_data = $urandom; rf_rt_data = $urandom;
    for (int i = 0; i < DEPTH; i++) stage_data[i*DW +: DW] = pipe[i].val;
    lookup(in.v && in.urs, in.rs, rf_rs_data, nrRs, e.rsSel, e.rsData);
    lookup(in.v && in.urt, in.rt, rf_rt_data, nrRt, e.rtSel, e.rtData);
    e.stall = in.v && !flush && (nrRs || nrRt);
    expQ.push_back(e);
    lastStall = e.stall;
`ifdef HZ_PERF_EN
    if (r) begin
      expStallCnt = 0; expFwdCnt = 0;
    end else begin
      if (e.stall) expStallCnt++;
      if (!e.stall && (e.rsSel != 0 || e.rtSel != 0)) expFwdCnt++;
    end
`endif
    n.v = in.v && !e.stall && !flush; n.we = in.we; n.ld = in.ld; n.dest = in.dest;
    n.val = n.v ? in.val : $urandom;
    if (r) begin
      foreach (pipe[i]) pipe[i].v = 0;
    end else begin
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
  endtask

  task automatic issue(input instr_t in, input bit flush);
    for (int k = 0; k < 8; k++) begin
      cycle(in, flush, 0);
      if (!lastStall) return;
    end
    chk("model_stall_bound", 1, 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("stall",   32'(stall),  32'(e.stall));
        if (!e.stall) begin
          chk("rs_sel",  32'(rs_sel), 32'(e.rsSel));
          chk("rt_sel",  32'(rt_sel), 32'(e.rtSel));
          chk("rs_data", rs_data,     e.rsData);
          chk("rt_data", rt_data,     e.rtData);
        end
      end
    end
  end

  initial begin
    instr_t t, ld8;
    entry_t b;
    b = '{v: 0, we: 0, ld: 0, dest: 0, val: 0};
    for (int i = 0; i < DEPTH; i++) pipe.push_back(b);
    repeat (2) @(posedge clk);

    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
    // Independent pair
    issue(mk(1, 2, 3, 1, 1, 1, 1, 0, 32'h1111), 0);
    issue(mk(1, 5, 6, 1, 1, 4, 1, 0, 32'h2222), 0);
    // ALU dependency
    issue(mk(1, 2, 3, 1, 1, 1, 1, 0, 32'h0000_0010), 0);
    issue(mk(1, 1, 0, 1, 1, 7, 1, 0, 32'h3333), 0);
    // Load-use
    issue(mk(1, 2, 0, 1, 0, 8, 1, 1, 32'hDEAD_BEEF), 0);
    issue(mk(1, 8, 8, 1, 1, 9, 1, 0, 32'h4444), 0);
    // Youngest wins
    issue(mk(1, 1, 2, 1, 1, 3, 1, 0, 32'd5), 0);
    issue(mk(1, 1, 2, 1, 1, 3, 1, 0, 32'd9), 0);
    issue(mk(1, 3, 3, 1, 1, 10, 1, 0, 32'h5555), 0);
    // Flush under stall
    issue(mk(1, 4, 0, 1, 0, 2, 1, 1, 32'h6666), 0);
    issue(mk(1, 2, 2, 1, 1, 11, 1, 0, 32'h7777), 1);
    issue(mk(1, 2, 0, 1, 0, 12, 1, 0, 32'h8888), 0);
    // r0 never matches
    issue(mk(1, 1, 2, 1, 1, 0, 1, 0, 32'h9999), 0);
    issue(mk(1, 0, 0, 1, 1, 13, 1, 0, 32'hAAAA), 0);
    // Reset during a load-use stall
    ld8 = mk(1, 8, 8, 1, 1, 9, 1, 0, 32'hBBBB);
    issue(mk(1, 2, 0, 1, 0, 8, 1, 1, 32'hCCCC), 0);
    cycle(ld8, 0, 0);
    cycle(ld8, 0, 1);
    cycle(ld8, 0, 0);

    for (int n = 0; n < 500; n++) begin
      t = mk($urandom_range(9) != 0, $urandom_range(3), $urandom_range(3),
             $urandom_range(1), $urandom_range(1), $urandom_range(3),
             $urandom_range(4) != 0, $urandom_range(2) == 0, $urandom);
      if ($urandom_range(49) == 0) cycle(t, 0, 1);
      else issue(t, $urandom_range(9) == 0);
    end
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);

    @(posedge clk);
    #1;
`ifdef HZ_PERF_EN
    chk("stall_cnt", stall_cnt, expStallCnt);
    chk("fwd_cnt",   fwd_cnt,   expFwdCnt);
`endif
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(expQ.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
